// File: rtl/mem_fill_arbiter.sv
// -----------------------------------------------------------------------------
// mem_fill_arbiter
//
// Owns the single shared main-memory port. Arbitrates between D-side
// write-through stores, D-cache miss fills and I-cache miss fills (in that
// priority order), sequences every block fill as back-to-back pipelined word
// reads, and steers the returned words into the granted cache's fill port.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   imiss_req/imiss_addr     I-cache miss request (level) and byte address
//   dmiss_req/dmiss_addr     D-cache miss request (level) and byte address
//   dwr_req/dwr_addr/dwr_data  D-side write-through store (level)
//   mem_addr/mem_enable/mem_wr/mem_data_in   memory command port
//   mem_data_out/mem_data_valid              memory read return port
//   fill_we_i/fill_we_d/fill_word/fill_data  cache fill write port
//   imiss_done/dmiss_done/dwr_ack            one-cycle completion pulses
// -----------------------------------------------------------------------------
module mem_fill_arbiter #(
   parameter int BLOCK_WORDS = 8,
   parameter int ADDR_W      = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           imiss_req,
   input  logic [ADDR_W-1:0]              imiss_addr,
   input  logic                           dmiss_req,
   input  logic [ADDR_W-1:0]              dmiss_addr,
   input  logic                           dwr_req,
   input  logic [ADDR_W-1:0]              dwr_addr,
   input  logic [15:0]                    dwr_data,
   output logic [ADDR_W-1:0]              mem_addr,
   output logic                           mem_enable,
   output logic                           mem_wr,
   output logic [15:0]                    mem_data_in,
   input  logic [15:0]                    mem_data_out,
   input  logic                           mem_data_valid,
   output logic                           fill_we_i,
   output logic                           fill_we_d,
   output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
   output logic [15:0]                    fill_data,
   output logic                           imiss_done,
   output logic                           dmiss_done,
   output logic                           dwr_ack
);

   localparam int WIDX_W = $clog2(BLOCK_WORDS);
   localparam int CNT_W  = WIDX_W + 1;

   localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(BLOCK_WORDS);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [WIDX_W-1:0] RET_LAST = WIDX_W'(BLOCK_WORDS - 1);
   localparam logic [WIDX_W-1:0] RET_ONE  = WIDX_W'(1);
   // A block spans BLOCK_WORDS 16-bit words, i.e. 2*BLOCK_WORDS bytes.
   localparam logic [ADDR_W-1:0] BASE_MASK = ~(ADDR_W'(2 * BLOCK_WORDS - 1));

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WRITE = 2'd1;
   localparam logic [1:0] ST_FILL  = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0]        state_q,     state_d;
   logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
   logic [WIDX_W-1:0] ret_cnt_q,   ret_cnt_d;
   logic              gnt_dside_q, gnt_dside_d;   // 1 = D-cache fill, 0 = I-cache fill
   logic [ADDR_W-1:0] base_q,      base_d;

   logic              issue_active_s;
   logic [ADDR_W-1:0] issue_ofs_s;

   // Issue phase lasts until every word of the block has been requested.
   assign issue_active_s = (state_q == ST_FILL) && (issue_cnt_q < CNT_FULL);
   assign issue_ofs_s    = ADDR_W'({issue_cnt_q, 1'b0});

   // Returned data is passed straight through; only the write enables gate it.
   assign fill_data = mem_data_out;

   // Next-state, counter and grant computation.
   always_comb begin
      state_d     = state_q;
      issue_cnt_d = issue_cnt_q;
      ret_cnt_d   = ret_cnt_q;
      gnt_dside_d = gnt_dside_q;
      base_d      = base_q;
      case (state_q)
         ST_IDLE: begin
            if (dwr_req) begin
               state_d = ST_WRITE;
            end else if (dmiss_req) begin
               gnt_dside_d = 1'b1;
               base_d      = dmiss_addr & BASE_MASK;
               state_d     = ST_FILL;
            end else if (imiss_req) begin
               gnt_dside_d = 1'b0;
               base_d      = imiss_addr & BASE_MASK;
               state_d     = ST_FILL;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WRITE: begin
            state_d = ST_IDLE;
         end
         ST_FILL: begin
            if (issue_active_s) begin
               issue_cnt_d = issue_cnt_q + CNT_ONE;
            end else begin
               issue_cnt_d = issue_cnt_q;
            end
            // Issue and return overlap; completion is driven by returns only.
            if (mem_data_valid) begin
               ret_cnt_d = ret_cnt_q + RET_ONE;
               if (ret_cnt_q == RET_LAST) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_FILL;
               end
            end else begin
               ret_cnt_d = ret_cnt_q;
            end
         end
         ST_DONE: begin
            issue_cnt_d = '0;
            ret_cnt_d   = '0;
            state_d     = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         issue_cnt_q <= '0;
         ret_cnt_q   <= '0;
         gnt_dside_q <= 1'b0;
         base_q      <= '0;
      end else begin
         state_q     <= state_d;
         issue_cnt_q <= issue_cnt_d;
         ret_cnt_q   <= ret_cnt_d;
         gnt_dside_q <= gnt_dside_d;
         base_q      <= base_d;
      end
   end

   // Output decode from the registered state; returns outside FILL are ignored.
   always_comb begin
      mem_addr    = '0;
      mem_enable  = 1'b0;
      mem_wr      = 1'b0;
      mem_data_in = 16'h0000;
      fill_we_i   = 1'b0;
      fill_we_d   = 1'b0;
      fill_word   = '0;
      imiss_done  = 1'b0;
      dmiss_done  = 1'b0;
      dwr_ack     = 1'b0;
      case (state_q)
         ST_WRITE: begin
            mem_enable  = 1'b1;
            mem_wr      = 1'b1;
            mem_addr    = dwr_addr;
            mem_data_in = dwr_data;
            dwr_ack     = 1'b1;
         end
         ST_FILL: begin
            if (issue_active_s) begin
               mem_enable = 1'b1;
               mem_addr   = base_q + issue_ofs_s;
            end else begin
               mem_enable = 1'b0;
            end
            fill_word = ret_cnt_q;
            if (mem_data_valid) begin
               fill_we_d = gnt_dside_q;
               fill_we_i = ~gnt_dside_q;
            end else begin
               fill_we_d = 1'b0;
               fill_we_i = 1'b0;
            end
         end
         ST_DONE: begin
            dmiss_done = gnt_dside_q;
            imiss_done = ~gnt_dside_q;
         end
         default: begin
            mem_enable = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_fill_arbiter.sv
module tb_mem_fill_arbiter;

   localparam int BW  = 8;
   localparam int LAT = 4;
   localparam int AW  = 16;

   localparam int K_NONE = 0;
   localparam int K_W    = 1;
   localparam int K_D    = 2;
   localparam int K_I    = 3;

   localparam logic [7:0] EV_W = 8'h57;
   localparam logic [7:0] EV_D = 8'h44;
   localparam logic [7:0] EV_I = 8'h49;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          imiss_req, dmiss_req, dwr_req;
   logic [AW-1:0] imiss_addr, dmiss_addr, dwr_addr;
   logic [15:0]   dwr_data;
   logic [AW-1:0] mem_addr;
   logic          mem_enable, mem_wr;
   logic [15:0]   mem_data_in, mem_data_out;
   logic          mem_data_valid;
   logic          fill_we_i, fill_we_d;
   logic [2:0]    fill_word;
   logic [15:0]   fill_data;
   logic          imiss_done, dmiss_done, dwr_ack;

   mem_fill_arbiter #(.BLOCK_WORDS(BW), .ADDR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .imiss_req(imiss_req), .imiss_addr(imiss_addr),
      .dmiss_req(dmiss_req), .dmiss_addr(dmiss_addr),
      .dwr_req(dwr_req), .dwr_addr(dwr_addr), .dwr_data(dwr_data),
      .mem_addr(mem_addr), .mem_enable(mem_enable), .mem_wr(mem_wr),
      .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
      .mem_data_valid(mem_data_valid),
      .fill_we_i(fill_we_i), .fill_we_d(fill_we_d), .fill_word(fill_word),
      .fill_data(fill_data), .imiss_done(imiss_done), .dmiss_done(dmiss_done),
      .dwr_ack(dwr_ack)
   );

   always #5 clk = ~clk;

   // Memory content as seen by reads: a fixed function of the word address.
   function automatic logic [15:0] pat(input logic [AW-1:0] a);
      return {a[7:0], a[15:8]} ^ 16'h3C5A;
   endfunction

   // Pipelined memory: a read issued in cycle t returns in cycle t+LAT.
   logic [LAT-1:0] pv_q = '0;
   logic [AW-1:0]  pa_q [LAT];
   logic           spur_v = 1'b0;
   always @(posedge clk) begin
      pv_q    <= {pv_q[LAT-2:0], mem_enable & ~mem_wr};
      pa_q[0] <= mem_addr;
      for (int j = 1; j < LAT; j++) pa_q[j] <= pa_q[j-1];
   end
   assign mem_data_valid = pv_q[LAT-1] | spur_v;
   assign mem_data_out   = pv_q[LAT-1] ? pat(pa_q[LAT-1]) : 16'hDEAD;

   typedef struct packed {
      logic        en, wr;
      logic [15:0] addr, din;
      logic        we_i, we_d;
      logic [2:0]  word;
      logic [15:0] data;
      logic        done_i, done_d, ack;
   } out_t;

   // Transaction-level model: which transaction owns the port, when it was
   // granted, and the first cycle the port is free again.
   typedef struct {
      int          kind;
      int          g;
      int          free_c;
      logic [15:0] base;
   } mdl_t;

   typedef struct packed {
      logic        w, d, i;
      logic [15:0] iaddr, daddr, waddr, wdata;
      logic [15:0] e_dbase, e_ibase;
      logic [7:0]  e_n;
      logic [2:0][7:0] e_ord;
   } vec_t;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   mdl_t mdl;
   logic prev_iss = 1'b0;
   logic [7:0]  ev_q [$];
   logic [15:0] base_log [$];
   logic [15:0] wa_log [$];
   logic [15:0] wd_log [$];
   int n_we_i = 0, n_we_d = 0, n_idone = 0, n_ddone = 0, n_ack = 0;
   int last_idone = 0, last_ack = 0;
   vec_t vecs [6];

   function automatic logic [15:0] blk_base(input logic [15:0] a);
      return a - (a % 16'(2 * BW));
   endfunction

   function automatic mdl_t mdl_next(input mdl_t m, input int c);
      mdl_t n;
      n = m;
      if (c >= m.free_c) begin
         n.g = c;
         if (dwr_req) begin
            n.kind = K_W; n.free_c = c + 2;
         end else if (dmiss_req) begin
            n.kind = K_D; n.base = blk_base(dmiss_addr); n.free_c = c + BW + LAT + 2;
         end else if (imiss_req) begin
            n.kind = K_I; n.base = blk_base(imiss_addr); n.free_c = c + BW + LAT + 2;
         end else begin
            n.kind = K_NONE; n.free_c = c;
         end
      end
      return n;
   endfunction

   function automatic out_t mdl_out(input mdl_t m, input int c);
      out_t e;
      int   off, w;
      e   = '0;
      off = c - m.g;
      if (m.kind == K_W && off == 1) begin
         e.en = 1'b1; e.wr = 1'b1; e.addr = dwr_addr; e.din = dwr_data; e.ack = 1'b1;
      end
      if (m.kind == K_D || m.kind == K_I) begin
         if (off >= 1 && off <= BW) begin
            e.en = 1'b1; e.addr = m.base + 16'(2 * (off - 1));
         end
         if (off >= LAT + 1 && off <= LAT + BW) begin
            w = off - LAT - 1;
            e.we_d = (m.kind == K_D); e.we_i = (m.kind == K_I);
            e.word = 3'(w); e.data = pat(m.base + 16'(2 * w));
         end
         if (off == BW + LAT + 1) begin
            e.done_d = (m.kind == K_D); e.done_i = (m.kind == K_I);
         end
      end
      return e;
   endfunction

   function automatic out_t act_pack();
      out_t a;
      a        = '0;
      a.en     = mem_enable;
      a.wr     = mem_wr;
      a.addr   = mem_enable ? mem_addr : 16'h0000;
      a.din    = (mem_enable && mem_wr) ? mem_data_in : 16'h0000;
      a.we_i   = fill_we_i;
      a.we_d   = fill_we_d;
      a.word   = (fill_we_i || fill_we_d) ? fill_word : 3'd0;
      a.data   = (fill_we_i || fill_we_d) ? fill_data : 16'h0000;
      a.done_i = imiss_done;
      a.done_d = dmiss_done;
      a.ack    = dwr_ack;
      return a;
   endfunction

   function automatic vec_t mkv(input logic w, d, i, input logic [15:0] ia, da, wa, wd,
                                input logic [15:0] eb_d, eb_i, input logic [7:0] n,
                                input logic [7:0] o0, o1, o2);
      vec_t v;
      v = '{w: w, d: d, i: i, iaddr: ia, daddr: da, waddr: wa, wdata: wd,
            e_dbase: eb_d, e_ibase: eb_i, e_n: n, e_ord: {o2, o1, o0}};
      return v;
   endfunction

   task automatic chk_out(input out_t e, input out_t a, input string name);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, a, e);
      end
   endtask

   task automatic chk_int(input int got, input int exp, input string name);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
      end
   endtask

   // One clock cycle: check at the falling edge, log events, then advance and
   // let requesters drop a request whose completion pulse was just seen.
   task automatic tick();
      out_t a;
      logic iss;
      @(negedge clk);
      a = act_pack();
      if (!rst_n) begin
         mdl.kind = K_NONE; mdl.g = 0; mdl.free_c = 0;
         chk_out('0, a, "reset_outputs");
      end else begin
         mdl = mdl_next(mdl, cyc);
         chk_out(mdl_out(mdl, cyc), a, "cycle_outputs");
      end
      iss = mem_enable & ~mem_wr;
      if (iss && !prev_iss) base_log.push_back(mem_addr);
      prev_iss = iss;
      if (mem_enable && mem_wr) begin wa_log.push_back(mem_addr); wd_log.push_back(mem_data_in); end
      if (fill_we_i) n_we_i++;
      if (fill_we_d) n_we_d++;
      if (dwr_ack)    begin ev_q.push_back(EV_W); n_ack++;   last_ack = cyc;   end
      if (dmiss_done) begin ev_q.push_back(EV_D); n_ddone++; end
      if (imiss_done) begin ev_q.push_back(EV_I); n_idone++; last_idone = cyc; end
      @(posedge clk);
      cyc++;
      #1;
      if (a.done_i) imiss_req = 1'b0;
      if (a.done_d) dmiss_req = 1'b0;
      if (a.ack)    dwr_req   = 1'b0;
   endtask

   task automatic run_until_quiet(input int maxc, input string name);
      int k;
      k = 0;
      while ((imiss_req || dmiss_req || dwr_req) && k < maxc) begin tick(); k++; end
      chk_int(int'(imiss_req || dmiss_req || dwr_req), 0, name);
      imiss_req = 1'b0; dmiss_req = 1'b0; dwr_req = 1'b0;
      tick(); tick();
   endtask

   task automatic run_vec(input vec_t v);
      int e0, b0, w0, k;
      e0 = ev_q.size(); b0 = base_log.size(); w0 = wa_log.size(); k = 0;
      dwr_req = v.w; dwr_addr = v.waddr; dwr_data = v.wdata;
      dmiss_req = v.d; dmiss_addr = v.daddr;
      imiss_req = v.i; imiss_addr = v.iaddr;
      run_until_quiet(80, "vec_timeout");
      chk_int(ev_q.size() - e0, int'(v.e_n), "vec_event_count");
      for (int j = 0; j < int'(v.e_n); j++) begin
         if (e0 + j < ev_q.size()) chk_int(int'(ev_q[e0+j]), int'(v.e_ord[j]), "vec_event_order");
         if (v.e_ord[j] != EV_W) begin
            if (b0 + k < base_log.size())
               chk_int(int'(base_log[b0+k]),
                       int'((v.e_ord[j] == EV_D) ? v.e_dbase : v.e_ibase), "vec_fill_base");
            k++;
         end
      end
      if (v.w && w0 < wa_log.size()) begin
         chk_int(int'(wa_log[w0]), int'(v.waddr), "vec_write_addr");
         chk_int(int'(wd_log[w0]), int'(v.wdata), "vec_write_data");
      end
   endtask

   initial begin
      int g, s_we_i, s_we_d, s_idone, s_ddone;
      vecs[0] = mkv(1'b0, 1'b0, 1'b1, 16'h1236, 16'h0000, 16'h0000, 16'h0000,
                    16'h0000, 16'h1230, 8'd1, EV_I, 8'h00, 8'h00);
      vecs[1] = mkv(1'b0, 1'b1, 1'b1, 16'h2345, 16'h0AB7, 16'h0000, 16'h0000,
                    16'h0AB0, 16'h2340, 8'd2, EV_D, EV_I, 8'h00);
      vecs[2] = mkv(1'b1, 1'b1, 1'b1, 16'h0005, 16'h7777, 16'h0040, 16'hBEEF,
                    16'h7770, 16'h0000, 8'd3, EV_W, EV_D, EV_I);
      vecs[3] = mkv(1'b0, 1'b1, 1'b0, 16'h0000, 16'hFFFE, 16'h0000, 16'h0000,
                    16'hFFF0, 16'h0000, 8'd1, EV_D, 8'h00, 8'h00);
      vecs[4] = mkv(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h1234, 16'hA5A5,
                    16'h0000, 16'h0000, 8'd1, EV_W, 8'h00, 8'h00);
      vecs[5] = mkv(1'b1, 1'b0, 1'b1, 16'h8009, 16'h0000, 16'h5678, 16'h0F0F,
                    16'h0000, 16'h8000, 8'd2, EV_W, EV_I, 8'h00);

      mdl = '{kind: K_NONE, g: 0, free_c: 0, base: 16'h0000};
      rst_n = 1'b0;
      imiss_req = 1'b0; dmiss_req = 1'b0; dwr_req = 1'b0;
      imiss_addr = 16'h0000; dmiss_addr = 16'h0000; dwr_addr = 16'h0000; dwr_data = 16'h0000;
      tick(); tick();
      rst_n = 1'b1;
      tick();

      for (int v = 0; v < 6; v++) run_vec(vecs[v]);

      // Single I miss: done exactly 13 cycles after the grant cycle.
      s_we_i = n_we_i; s_we_d = n_we_d; s_idone = n_idone;
      imiss_req = 1'b1; imiss_addr = 16'h1236; g = cyc;
      run_until_quiet(40, "imiss_timeout");
      chk_int(last_idone - g, 13, "imiss_done_latency");
      chk_int(n_we_i - s_we_i, 8, "imiss_fill_we_i_count");
      chk_int(n_we_d - s_we_d, 0, "imiss_fill_we_d_count");
      chk_int(n_idone - s_idone, 1, "imiss_done_count");

      // Store arriving mid I fill waits until the fill is finished.
      imiss_req = 1'b1; imiss_addr = 16'h2000;
      tick(); tick(); tick();
      dwr_req = 1'b1; dwr_addr = 16'h0040; dwr_data = 16'hBEEF;
      run_until_quiet(40, "store_wait_timeout");
      chk_int(last_ack - last_idone, 2, "store_after_done_gap");
      chk_int(int'(ev_q[ev_q.size()-1]), int'(EV_W), "store_after_fill_order");

      // Requester withdrawing mid fill still gets the whole fill and done.
      s_we_d = n_we_d; s_ddone = n_ddone;
      dmiss_req = 1'b1; dmiss_addr = 16'h3008;
      tick(); tick(); tick();
      dmiss_req = 1'b0;
      for (int k = 0; k < 16; k++) tick();
      chk_int(n_we_d - s_we_d, 8, "dropped_req_fill_count");
      chk_int(n_ddone - s_ddone, 1, "dropped_req_done_count");

      // A stray valid while idle must not write or advance the word count.
      s_we_i = n_we_i; s_we_d = n_we_d;
      spur_v = 1'b1;
      tick();
      spur_v = 1'b0;
      chk_int((n_we_i - s_we_i) + (n_we_d - s_we_d), 0, "idle_valid_ignored");
      imiss_req = 1'b1; imiss_addr = 16'h5550;
      run_until_quiet(40, "post_stray_timeout");
      chk_int(n_we_i - s_we_i, 8, "post_stray_fill_count");

      // Reset in the middle of a fill with reads still in flight.
      imiss_req = 1'b1; imiss_addr = 16'h4444;
      for (int k = 0; k < 7; k++) tick();
      #2;
      rst_n = 1'b0; imiss_req = 1'b0;
      #1;
      chk_out('0, act_pack(), "async_reset_outputs");
      chk_int(int'(fill_data), int'(mem_data_out), "reset_fill_data_follows");
      tick(); tick();
      rst_n = 1'b1;
      s_we_i = n_we_i; s_idone = n_idone;
      for (int k = 0; k < 8; k++) tick();
      chk_int(n_we_i - s_we_i, 0, "stale_valid_no_fill");
      chk_int(n_idone - s_idone, 0, "stale_valid_no_done");
      imiss_req = 1'b1; imiss_addr = 16'h4444;
      run_until_quiet(40, "rerequest_timeout");
      chk_int(n_we_i - s_we_i, 8, "rerequest_fill_count");
      chk_int(n_idone - s_idone, 1, "rerequest_done_count");

      // Random traffic checked cycle by cycle against the transaction model.
      for (int n = 0; n < 3000; n++) begin
         tick();
         if (!dwr_req && $urandom_range(0, 15) == 0) begin
            dwr_req = 1'b1; dwr_addr = 16'($urandom); dwr_data = 16'($urandom);
         end
         if (!dmiss_req && $urandom_range(0, 9) == 0) dmiss_req = 1'b1;
         if (!imiss_req && $urandom_range(0, 7) == 0) imiss_req = 1'b1;
         dmiss_addr = 16'($urandom);
         imiss_addr = 16'($urandom);
      end
      run_until_quiet(300, "random_drain_timeout");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_fill_arbiter.md
Name: mem_fill_arbiter

Overview:
- Owns the single shared multi-cycle main-memory port. Arbitrates between I-cache miss fills, D-cache miss fills and D-side write-through stores.
- Sequences each block fill as back-to-back pipelined word reads. Returned words are steered into the granted cache's fill port.
- Sits between the Fetch/Memory-stage caches and the pipelined main-memory model. The pipeline stalls on the cache miss lines until the matching done pulse.

Parameters:
- BLOCK_WORDS, 8: 16-bit words per cache block. Power of two, at least 2.
- ADDR_W, 16: byte address width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- imiss_req  in  1  I-cache miss pending; level, held until imiss_done
- imiss_addr  in  ADDR_W  I-side miss byte address
- dmiss_req  in  1  D-cache miss pending; level, held until dmiss_done
- dmiss_addr  in  ADDR_W  D-side miss byte address
- dwr_req  in  1  D-side write-through store; level, held until dwr_ack
- dwr_addr  in  ADDR_W  store byte address
- dwr_data  in  16  store data
- mem_addr  out  ADDR_W  memory address
- mem_enable  out  1  memory access strobe
- mem_wr  out  1  memory write enable
- mem_data_in  out  16  memory write data
- mem_data_out  in  16  memory read data
- mem_data_valid  in  1  read data valid, fixed latency after issue
- fill_we_i  out  1  write fill_data into the I-cache
- fill_we_d  out  1  write fill_data into the D-cache
- fill_word  out  log2(BLOCK_WORDS)  word index within the block
- fill_data  out  16  returned word; equals mem_data_out
- imiss_done  out  1  one-cycle pulse; I fill complete
- dmiss_done  out  1  one-cycle pulse; D fill complete
- dwr_ack  out  1  one-cycle pulse; store issued

Behaviour:
- Reset (async, rst_n=0):
  - State becomes IDLE; issue and return counters clear to 0; grant register clears.
  - All outputs 0, except that fill_data continues to follow mem_data_out.
- States are IDLE, WRITE, FILL and DONE.
- IDLE:
  - Priority order is dwr_req > dmiss_req > imiss_req; at most one grant per cycle.
  - On dwr_req, go to WRITE.
  - On a miss request:
    - Latch the requester (grant bit).
    - Latch base = addr with the low log2(BLOCK_WORDS)+1 bits cleared.
    - Go to FILL.
  - No memory outputs are asserted in IDLE.
- WRITE (1 cycle):
  - mem_enable=1, mem_wr=1, mem_addr=dwr_addr, mem_data_in=dwr_data, dwr_ack=1.
  - Next state is IDLE.
- FILL:
  - Issue phase: while issue count k < BLOCK_WORDS, drive mem_enable=1, mem_wr=0, mem_addr=base+2k; k increments each cycle.
  - Return phase: each cycle with mem_data_valid=1, pulse fill_we_i or fill_we_d according to the grant. fill_word = return count r, which then increments.
  - Issue and return overlap. Address arithmetic is modulo 2^ADDR_W; a block never straddles wrap because base is aligned.
  - When the last word returns (r == BLOCK_WORDS-1 with valid), go to DONE.
- DONE (1 cycle):
  - Pulse imiss_done or dmiss_done according to the grant.
  - Clear the counters; go to IDLE.
  - Requests are re-evaluated in the following IDLE cycle, so back-to-back transactions have one IDLE cycle between them.
- Fill latency from the IDLE grant cycle: 1 + BLOCK_WORDS-1 + memory latency + 1 (DONE).
  - For BLOCK_WORDS=8 and 4-cycle memory: grant at cycle 0, issues at cycles 1..8, valids at cycles 5..12, done at cycle 13.
- Arbitration rules:
  - A request arriving mid-transaction waits and is never dropped.
  - A lower-priority requester waits at most one higher-priority transaction per higher-priority requester. No preemption.
  - Requests and addresses are sampled only in IDLE. Changing an address mid-fill has no effect.
- mem_data_valid outside FILL is ignored: no fill_we, no counter change.
- A requester that drops its request mid-fill does not abort the fill; the done pulse is still emitted.
- Async reset mid-FILL aborts the fill. Late returns after reset are ignored per the rule above. Requesters re-request.

Test Plan:
- Single I miss, imiss_addr=0x1236, 4-cycle memory -> mem_addr 0x1230,0x1232..0x123E on cycles 1..8; fill_we_i with fill_word 0..7 on cycles 5..12; imiss_done on cycle 13 only; fill_we_d never set.
- imiss_req and dmiss_req raised in the same cycle -> D fill on 0xXXX0 block first with dmiss_done; one IDLE cycle; then I fill starts; imiss_done follows.
- dwr_req (addr 0x0040, data 0xBEEF) raised during an I fill -> no mem_wr until after imiss_done; then a one-cycle write with mem_wr=1, mem_addr=0x0040, mem_data_in=0xBEEF, dwr_ack=1.
- dwr_req, dmiss_req and imiss_req all raised together -> order WRITE, D fill, I fill; exactly one ack/done pulse each.
- dmiss_addr=0xFFFE -> issued addresses 0xFFF0..0xFFFE with no wrap; fill_word 7 gets the word at 0xFFFE.
- rst_n pulsed low at cycle 7 of a fill with memory still returning -> outputs 0 immediately; no fill_we or done pulses from stale valids; a re-request completes a clean fill.
